// File: rtl/gpi_rx_filter.sv
// gpi_rx_filter: pad input-enable, synchroniser, glitch filter, edge pulses and interrupt.
// Latency pad->DI_O is SYNC_STAGES+N; no backpressure. `GPI_RX_EDGE_CNT_EN adds EDGE_CNT_O.
module gpi_rx_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 8,
  parameter int SETTLE_CYC  = 4
) (
  input  logic          CLK_I,
  input  logic          RST_NI,
  input  logic          EN_I,
  input  logic          PAD_DI_I,
  input  logic [CW-1:0] FILT_LEN_I,
  input  logic [1:0]    IRQ_MODE_I,
  input  logic          IRQ_CLR_I,
  output logic          IE_O,
  output logic          DI_O,
  output logic          RISE_O,
  output logic          FALL_O,
  output logic          IRQ_O
`ifdef GPI_RX_EDGE_CNT_EN
  ,
  output logic [15:0]   EDGE_CNT_O
`endif
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_DIS    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          settle_q, settle_d;
  logic                   ie_q, ie_d;
  logic                   di_q, di_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sticky_q, sticky_d;
  logic                   sync_s;
  logic                   level_mode;
  logic                   qual;
  logic [CW-1:0]          filt_last;

  assign sync_s     = sync_q[SYNC_STAGES-1];
  assign level_mode = (IRQ_MODE_I == 2'b11);
  assign filt_last  = (FILT_LEN_I == '0) ? '0 : (FILT_LEN_I - CW'(1));

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], PAD_DI_I};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_DIS:    if (EN_I) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (!EN_I)                        state_d = ST_DIS;
        else if (settle_q == SETTLE_LAST) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: if (!EN_I) state_d = ST_DIS;
      default:   state_d = ST_DIS;
    endcase
  end

  always_comb begin
    di_d     = di_q;
    cnt_d    = cnt_q;
    settle_d = '0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    ie_d     = (state_d != ST_DIS);
    unique case (state_q)
      ST_DIS: begin
        di_d  = 1'b0;
        cnt_d = '0;
      end
      ST_SETTLE: begin
        cnt_d = '0;
        if (EN_I) begin
          di_d     = sync_s;
          settle_d = settle_q + SW'(1);
        end else begin
          di_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (!EN_I) begin
          // Disable drops the level silently; no FALL_O.
          di_d  = 1'b0;
          cnt_d = '0;
        end else if (sync_s == di_q) begin
          cnt_d = '0;
        end else if (cnt_q >= filt_last) begin
          // >= so a lowered FILT_LEN_I toggles on the next mismatch.
          di_d   = ~di_q;
          cnt_d  = '0;
          rise_d = ~di_q;
          fall_d = di_q;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        di_d  = 1'b0;
        cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    unique case (IRQ_MODE_I)
      2'b00:   qual = rise_d;
      2'b01:   qual = fall_d;
      2'b10:   qual = rise_d | fall_d;
      default: qual = 1'b0;
    endcase
    sticky_d = sticky_q;
    // Held clear in level mode, so leaving level mode starts from a clean flag.
    if (level_mode)     sticky_d = 1'b0;
    else if (qual)      sticky_d = 1'b1;
    else if (IRQ_CLR_I) sticky_d = 1'b0;
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q  <= ST_DIS;
      sync_q   <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      ie_q     <= 1'b0;
      di_q     <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      ie_q     <= ie_d;
      di_q     <= di_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= sticky_d;
    end
  end

  assign IE_O   = ie_q;
  assign DI_O   = di_q;
  assign RISE_O = rise_q;
  assign FALL_O = fall_q;
  assign IRQ_O  = level_mode ? ((state_q == ST_ACTIVE) && di_q) : sticky_q;

`ifdef GPI_RX_EDGE_CNT_EN
  logic [15:0] ecnt_q, ecnt_d;

  always_comb begin
    ecnt_d = ecnt_q;
    if (level_mode)                      ecnt_d = '0;
    else if (IRQ_CLR_I)                  ecnt_d = qual ? 16'd1 : 16'd0;
    else if (qual && ecnt_q != 16'hFFFF) ecnt_d = ecnt_q + 16'd1;
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) ecnt_q <= '0;
    else         ecnt_q <= ecnt_d;
  end

  assign EDGE_CNT_O = level_mode ? 16'd0 : ecnt_q;
`endif

endmodule

// File: tb/tb_gpi_rx_filter.sv
// Directed bench for gpi_rx_filter: enable/settle, filtering, edges, interrupt modes, reset.
module tb_gpi_rx_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       pad;
  logic [7:0] filt;
  logic [1:0] mode;
  logic       clr;
  logic       ie, di, rise, fall, irq;
`ifdef GPI_RX_EDGE_CNT_EN
  logic [15:0] edge_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gpi_rx_filter #(.SYNC_STAGES(2), .CW(8), .SETTLE_CYC(4)) dut (
    .CLK_I      (clk),
    .RST_NI     (rst_n),
    .EN_I       (en),
    .PAD_DI_I   (pad),
    .FILT_LEN_I (filt),
    .IRQ_MODE_I (mode),
    .IRQ_CLR_I  (clr),
    .IE_O       (ie),
    .DI_O       (di),
    .RISE_O     (rise),
    .FALL_O     (fall),
    .IRQ_O      (irq)
`ifdef GPI_RX_EDGE_CNT_EN
    ,
    .EDGE_CNT_O (edge_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; pad = 1'b1; filt = 8'd5; mode = 2'b11; clr = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ie, di, rise, fall, irq} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000", {ie, di, rise, fall, irq});
    end
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  // Pad already high: DI_O follows during SETTLE, level IRQ only once ACTIVE.
  task automatic test_enable();
    en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if ({ie, di, irq, rise} !== {1'b1, (i >= 2), (i == 5), 1'b0}) begin
        failures++;
        $display("FAIL enable_settle cyc=%0d got ie/di/irq/rise=%b exp=%b", i,
                 {ie, di, irq, rise}, {1'b1, (i >= 2), (i == 5), 1'b0});
      end
    end
  endtask

  task automatic test_debounce_fall();
    mode = 2'b00; filt = 8'd5; pad = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if ({di, fall, rise, irq} !== {(i < 7), (i == 7), 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL debounce_fall cyc=%0d got di/fall/rise/irq=%b exp=%b", i,
                 {di, fall, rise, irq}, {(i < 7), (i == 7), 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_glitch();
    pad = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 4) pad = 1'b0;
      checks++;
      if ({di, rise, irq} !== 3'b000) begin
        failures++;
        $display("FAIL glitch_reject cyc=%0d got di/rise/irq=%b exp=000", i, {di, rise, irq});
      end
    end
  endtask

  task automatic test_debounce_rise();
    pad = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if ({di, rise, irq} !== {(i >= 7), (i == 7), (i >= 7)}) begin
        failures++;
        $display("FAIL debounce_rise cyc=%0d got di/rise/irq=%b exp=%b", i,
                 {di, rise, irq}, {(i >= 7), (i == 7), (i >= 7)});
      end
    end
  endtask

  task automatic test_clear_race();
    mode = 2'b10;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL lone_clear got=%b exp=0", irq);
    end
    pad = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 6) clr = 1'b1;
      if (i == 7) clr = 1'b0;
      checks++;
      if ({di, fall, irq} !== {(i < 7), (i == 7), (i >= 7)}) begin
        failures++;
        $display("FAIL clear_race cyc=%0d got di/fall/irq=%b exp=%b", i,
                 {di, fall, irq}, {(i < 7), (i == 7), (i >= 7)});
      end
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL later_clear got=%b exp=0", irq);
    end
  endtask

  task automatic test_filt_len();
    filt = 8'd0;
    pad  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if ({di, rise} !== {(i >= 3), (i == 3)}) begin
        failures++;
        $display("FAIL filt_zero cyc=%0d got di/rise=%b exp=%b", i, {di, rise}, {(i >= 3), (i == 3)});
      end
    end
    filt = 8'd10;
    pad  = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 8) filt = 8'd3;
      checks++;
      if ({di, fall} !== {(i < 9), (i == 9)}) begin
        failures++;
        $display("FAIL filt_lowered cyc=%0d got di/fall=%b exp=%b", i, {di, fall}, {(i < 9), (i == 9)});
      end
    end
  endtask

`ifdef GPI_RX_EDGE_CNT_EN
  task automatic test_edge_cnt();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (edge_cnt !== 16'd0) begin
      failures++;
      $display("FAIL edge_cnt_clear got=%0d exp=0", edge_cnt);
    end
    for (int p = 0; p < 3; p++) begin
      pad = 1'b1;
      repeat (8) tick();
      pad = 1'b0;
      repeat (8) tick();
    end
    checks++;
    if (edge_cnt !== 16'd6) begin
      failures++;
      $display("FAIL edge_cnt_six got=%0d exp=6", edge_cnt);
    end
    pad = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 4) clr = 1'b1;
      if (i == 5) clr = 1'b0;
    end
    checks++;
    if ({edge_cnt, irq} !== {16'd1, 1'b1}) begin
      failures++;
      $display("FAIL edge_cnt_clear_race got cnt=%0d irq=%b exp cnt=1 irq=1", edge_cnt, irq);
    end
    pad = 1'b0;
    repeat (8) tick();
  endtask
`endif

  task automatic test_level_disable();
    mode = 2'b10; filt = 8'd3;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    pad = 1'b1;
    repeat (6) tick();
    checks++;
    if ({di, irq} !== 2'b11) begin
      failures++;
      $display("FAIL sticky_set got di/irq=%b exp=11", {di, irq});
    end
    en = 1'b0;
    tick();
    checks++;
    if ({ie, di, fall, irq} !== 4'b0001) begin
      failures++;
      $display("FAIL disable_sticky got ie/di/fall/irq=%b exp=0001", {ie, di, fall, irq});
    end
    mode = 2'b11;
    tick();
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL level_disabled got=%b exp=0", irq);
    end
    mode = 2'b00;
    tick();
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL leave_level_clears got=%b exp=0", irq);
    end
    mode = 2'b11;
    en   = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if ({irq, rise} !== {(i == 5), 1'b0}) begin
        failures++;
        $display("FAIL level_reenable cyc=%0d got irq/rise=%b exp=%b", i, {irq, rise}, {(i == 5), 1'b0});
      end
    end
    en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if ({ie, di, irq, fall} !== 4'b0000) begin
        failures++;
        $display("FAIL level_disable cyc=%0d got ie/di/irq/fall=%b exp=0000", i, {ie, di, irq, fall});
      end
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; mode = 2'b11; filt = 8'd5; pad = 1'b1;
    repeat (5) tick();
    checks++;
    if ({di, irq} !== 2'b11) begin
      failures++;
      $display("FAIL pre_reset_active got di/irq=%b exp=11", {di, irq});
    end
    pad = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ie, di, rise, fall, irq} !== 5'b0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=00000", {ie, di, rise, fall, irq});
    end
    pad = 1'b1;
    tick();
    rst_n = 1'b1;
    checks++;
    if (ie !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_ie got=%b exp=0", ie);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if ({ie, di, irq} !== {1'b1, (i >= 3), (i == 5)}) begin
        failures++;
        $display("FAIL resettle cyc=%0d got ie/di/irq=%b exp=%b", i, {ie, di, irq}, {1'b1, (i >= 3), (i == 5)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_debounce_fall();
    test_glitch();
    test_debounce_rise();
    test_clear_race();
    test_filt_len();
`ifdef GPI_RX_EDGE_CNT_EN
    test_edge_cnt();
`endif
    test_level_disable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
